sseg_scan_driver: RTL

//  Downstream display stage for the single-cycle datapath. Latches a 16-bit value and scans it

---
 rtl/sseg_scan_driver_if.sv | 28 ++
 rtl/sseg_scan_driver.sv | 117 +++++++++++
 2 files changed

// File: rtl/sseg_scan_driver_if.sv
//------------------------------------------------------------------------------
// Module  : sseg_scan_driver_if
// Brief   : Display-value inputs and multiplexed seven-segment outputs.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface sseg_scan_driver_if;
  logic [15:0] value;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [6:0]  sseg_cathode;
  logic        sseg_dp;
  logic [3:0]  sseg_anode;

  modport master (
    output value, load, blank_lz, dp_mask,
    input  sseg_cathode, sseg_dp, sseg_anode
  );

  modport slave (
    input  value, load, blank_lz, dp_mask,
    output sseg_cathode, sseg_dp, sseg_anode
  );
endinterface

`default_nettype wire

// File: rtl/sseg_scan_driver.sv
//------------------------------------------------------------------------------
// Module  : sseg_scan_driver
// Brief   : Latches a 16-bit value and scans it as hex over a 4-digit display.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sseg_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  wire logic        clk,
  input  wire logic        reset,
  sseg_scan_driver_if.slave bus
);

  localparam int                  PRESC_W    = $clog2(REFRESH_DIV);
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);

  generate
    if (REFRESH_DIV < 2) begin : g_bad_div
      $error("sseg_scan_driver: REFRESH_DIV must be >= 2");
    end
  endgenerate

  logic [PRESC_W-1:0] presc;
  logic [1:0]         digit;
  logic [15:0]        shown;
  logic [3:0]         anode;
  logic [6:0]         cathode;
  logic               dp;

  logic [3:0]         nibble;
  logic               lz_blank;
  logic               slot_end;
  logic [3:0]         anode_nx;
  logic [6:0]         cathode_nx;
  logic               dp_nx;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] seg;
    case (n)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  assign slot_end = (presc == PRESC_LAST);

  always_comb begin
    nibble   = shown[4*digit +: 4];
    lz_blank = 1'b0;
    case (digit)
      2'd1:    lz_blank = (shown[15:4]  == 12'h000);
      2'd2:    lz_blank = (shown[15:8]  == 8'h00);
      2'd3:    lz_blank = (shown[15:12] == 4'h0);
      default: lz_blank = 1'b0;
    endcase
  end

  // Last clock of each slot is dark so the previous digit cannot ghost into the next.
  always_comb begin
    anode_nx   = 4'b1111;
    cathode_nx = 7'h7F;
    dp_nx      = 1'b1;
    if (!slot_end) begin
      anode_nx   = ~(4'b0001 << digit);
      cathode_nx = (bus.blank_lz && lz_blank) ? 7'h7F : hex7(nibble);
      dp_nx      = ~bus.dp_mask[digit];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc   <= '0;
      digit   <= 2'd0;
      shown   <= 16'h0000;
      anode   <= 4'b1111;
      cathode <= 7'h7F;
      dp      <= 1'b1;
    end else begin
      if (bus.load) begin
        shown <= bus.value;
      end
      if (slot_end) begin
        presc <= '0;
        digit <= digit + 2'd1;
      end else begin
        presc <= presc + PRESC_W'(1);
      end
      anode   <= anode_nx;
      cathode <= cathode_nx;
      dp      <= dp_nx;
    end
  end

  assign bus.sseg_anode   = anode;
  assign bus.sseg_cathode = cathode;
  assign bus.sseg_dp      = dp;

endmodule

`default_nettype wire
